mul_sequencer: RTL

Multi-cycle controller that executes ARM MUL/MLA (32x32 -> low 32 bits) by driving the shared ALU with repeated ADD (cmd 4'b0010) operations, one shift-add step per cycle.
Sits in the execute stage beside the ALU. While the sequencer is active, aluOwn steers the ALU input mux to the sequencer.
Terminates early once the remaining multiplier bits are zero.

---
 rtl/mul_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//   Multi-cycle controller for ARM MUL/MLA (WIDTH x WIDTH -> low WIDTH bits).
//   It borrows the shared execute-stage ALU and issues one ADD per cycle,
//   performing a classic shift-add multiply:
//     P += Q[0] ? M : 0;  M <<= 1;  Q >>= 1;
//   The loop ends early as soon as the remaining multiplier bits are zero, so
//   an operation takes (index of highest set bit of rs)+1 RUN cycles.
//
// Ports
//   clk, rstN        : clock (rising edge), asynchronous active-low reset
//   start, flush     : request (accepted only in IDLE), synchronous abort
//   accumulate       : 1 = MLA (P starts at rn), 0 = MUL (P starts at 0)
//   setFlags         : S bit, write N/Z on completion
//   rm, rs, rn       : multiplicand, multiplier, accumulate operand
//   nzcvIn           : current status; C/V are latched at start and preserved
//   aluResult        : combinational result of the shared ALU
//   aluOwn           : sequencer drives the ALU this cycle
//   aluVal1/2, aluCmd, aluCarryIn : ALU operands and command
//   busy, done       : not-idle, one-cycle completion pulse
//   result           : product, held from done until the next accepted start
//   flagsWe, nzcvOut : status write enable and value
// -----------------------------------------------------------------------------
module mul_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ADD_CMD = 4'b0010
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic             flush,
    input  logic             accumulate,
    input  logic             setFlags,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rn,
    input  logic [3:0]       nzcvIn,
    input  logic [WIDTH-1:0] aluResult,
    output logic             aluOwn,
    output logic [WIDTH-1:0] aluVal1,
    output logic [WIDTH-1:0] aluVal2,
    output logic [3:0]       aluCmd,
    output logic             aluCarryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flagsWe,
    output logic [3:0]       nzcvOut
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;        // multiplicand, shifted left each step
    logic [WIDTH-1:0] q_q, q_d;        // multiplier, shifted right each step
    logic [WIDTH-1:0] p_q, p_d;        // running partial product
    logic [WIDTH-1:0] result_q, result_d;
    logic             sflag_q, sflag_d;
    logic [1:0]       cv_q, cv_d;      // C/V captured at start, reported unchanged

    logic             in_run;
    logic             in_done;

    // N and Z of the incoming status are recomputed from the product, so only
    // C/V are consumed here.
    logic             unused_nz;
    assign unused_nz = ^nzcvIn[3:2];

    assign in_run  = (state_q == S_RUN);
    assign in_done = (state_q == S_DONE);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        q_d      = q_q;
        p_d      = p_q;
        result_d = result_q;
        sflag_d  = sflag_q;
        cv_d     = cv_q;

        if (flush) begin
            // Abort wins over everything, including a start in IDLE; the
            // previously delivered result is left untouched.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        m_d     = rm;
                        q_d     = rs;
                        p_d     = accumulate ? rn : '0;
                        sflag_d = setFlags;
                        cv_d    = nzcvIn[1:0];
                        // A zero multiplier needs no ALU steps at all.
                        state_d = (rs != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    p_d = aluResult;
                    m_d = m_q << 1;
                    q_d = q_q >> 1;
                    // This step consumes Q[0]; if nothing remains above it,
                    // the product is complete after this edge.
                    if (q_q[WIDTH-1:1] == '0) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here.
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Capture the product on the edge that enters DONE, so result is
            // already valid in the done cycle and holds afterwards.
            if (state_d == S_DONE && state_q != S_DONE) begin
                result_d = p_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            q_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            sflag_q  <= 1'b0;
            cv_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            q_q      <= q_d;
            p_q      <= p_d;
            result_q <= result_d;
            sflag_q  <= sflag_d;
            cv_q     <= cv_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // ALU drive is forced to zero outside RUN so the operand mux sees a quiet
    // bus whenever the pipeline owns the ALU.
    assign aluOwn     = in_run;
    assign aluCmd     = in_run ? ADD_CMD : 4'b0000;
    assign aluVal1    = in_run ? p_q : '0;
    assign aluVal2    = (in_run && q_q[0]) ? m_q : '0;
    assign aluCarryIn = 1'b0;

    assign busy    = (state_q != S_IDLE);
    assign done    = in_done;
    assign result  = result_q;
    assign flagsWe = in_done & sflag_q;
    assign nzcvOut = in_done ? {p_q[WIDTH-1], (p_q == '0), cv_q} : 4'b0000;

endmodule
